iter_compare: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle flag comparer in the CPU's branch/set-less-than path.
- Compares two WIDTH-bit operands, signed or unsigned, CHUNK bits per cycle, MSB-first, with early termination.
- Produces eql, slt and a branch-take decision for a selected condition.
- Sits beside the ALU as a decoupled unit with valid/ready handshakes on both sides.

---
 rtl/iter_compare.sv | 147 ++++++++++++++
 tb/tb_iter_compare.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/iter_compare.sv
// rtl/iter_compare.sv - multi-cycle MSB-first chunked signed/unsigned comparer with branch-take decision
// Optional macro: ITER_COMPARE_EARLY_EXIT_EN (stop scanning at the first differing chunk)
module iter_compare #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_cmp,
  input  logic [2:0]       cond,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eql,
  output logic             slt,
  output logic             take
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = '0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       cond_r;
  logic [IDX_W-1:0] idx;

  // Operands are shifted left after every scanned chunk, so the chunk under
  // test is always the top CHUNK bits; idx only counts remaining chunks.
  logic [CHUNK-1:0] a_top;
  logic [CHUNK-1:0] b_top;
  logic             chunk_ne;
  logic             chunk_lt;
  logic             scan_done;
  logic             scan_eq;
  logic             scan_lt;

`ifndef ITER_COMPARE_EARLY_EXIT_EN
  // Full-scan build: remember the first (most significant) difference seen.
  logic found;
  logic lt_acc;
  logic found_n;
  logic lt_n;
`endif

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Branch condition evaluation; reserved codes never take.
  function automatic logic eval_take(input logic [2:0] c, input logic eq, input logic lt);
    case (c)
      3'b000:  eval_take = eq;
      3'b001:  eval_take = !eq;
      3'b010:  eval_take = lt;
      3'b011:  eval_take = !lt;
      3'b100:  eval_take = lt | eq;
      3'b101:  eval_take = !lt & !eq;
      default: eval_take = 1'b0;
    endcase
  endfunction

  // Current-chunk compare and the scan step's completion/result decision.
  always_comb begin
    a_top    = a_r[WIDTH-1 -: CHUNK];
    b_top    = b_r[WIDTH-1 -: CHUNK];
    chunk_ne = (a_top != b_top);
    chunk_lt = (a_top < b_top);
`ifdef ITER_COMPARE_EARLY_EXIT_EN
    scan_done = chunk_ne || (idx == IDX_ZERO);
    scan_eq   = !chunk_ne;
    scan_lt   = chunk_lt;
`else
    found_n   = found | chunk_ne;
    lt_n      = found ? lt_acc : chunk_lt;
    scan_done = (idx == IDX_ZERO);
    scan_eq   = !found_n;
    scan_lt   = lt_n;
`endif
  end

  // Control FSM, operand capture/shift and registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      cond_r <= '0;
      idx    <= '0;
      eql    <= 1'b0;
      slt    <= 1'b0;
      take   <= 1'b0;
`ifndef ITER_COMPARE_EARLY_EXIT_EN
      found  <= 1'b0;
      lt_acc <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            // Flipping both sign bits maps two's-complement order onto unsigned order.
            a_r    <= a ^ (WIDTH'(signed_cmp) << (WIDTH - 1));
            b_r    <= b ^ (WIDTH'(signed_cmp) << (WIDTH - 1));
            cond_r <= cond;
            idx    <= IDX_LAST;
            state  <= S_SCAN;
`ifndef ITER_COMPARE_EARLY_EXIT_EN
            found  <= 1'b0;
            lt_acc <= 1'b0;
`endif
          end
        end
        S_SCAN: begin
          if (scan_done) begin
            eql   <= scan_eq;
            slt   <= scan_lt;
            take  <= eval_take(cond_r, scan_eq, scan_lt);
            state <= S_DONE;
          end else begin
            a_r <= a_r << CHUNK;
            b_r <= b_r << CHUNK;
            idx <= idx - IDX_W'(1);
`ifndef ITER_COMPARE_EARLY_EXIT_EN
            found  <= found_n;
            lt_acc <= lt_n;
`endif
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_compare.sv
// tb/tb_iter_compare.sv - directed self-checking bench for iter_compare
module tb_iter_compare;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int NCHUNK = WIDTH / CHUNK;
`ifdef ITER_COMPARE_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_cmp;
  logic [2:0]       cond;
  logic             out_valid;
  logic             out_ready;
  logic             eql;
  logic             slt;
  logic             take;

  int errors;
  int checks;

  iter_compare #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .signed_cmp(signed_cmp),
    .cond(cond),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .eql(eql),
    .slt(slt),
    .take(take)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_lat(input int k_early);
    exp_lat = EARLY ? k_early : NCHUNK;
  endfunction

  // Present operands for one accept edge, then drop in_valid.
  task automatic start_cmp(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                           input logic sg, input logic [2:0] cd);
    @(negedge clk);
    a = va;
    b = vb;
    signed_cmp = sg;
    cond = cd;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = '1;
    b = '0;
  endtask

  // Count edges after the accept edge until out_valid; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || eql !== 1'b0 || slt !== 1'b0 || take !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b eql=%b slt=%b take=%b want 1 0 0 0 0",
               in_ready, out_valid, eql, slt, take);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One compare with its latency and all three results checked inline.
  task automatic test_vector(input string name, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                             input logic sg, input logic [2:0] cd, input int k_early,
                             input logic e_eql, input logic e_slt, input logic e_take);
    int lat;
    start_cmp(va, vb, sg, cd);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: in_ready=%b want 0", name, in_ready);
    end
    wait_done(lat);
    checks++;
    if (lat != exp_lat(k_early)) begin
      errors++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat(k_early));
    end
    checks++;
    if (eql !== e_eql || slt !== e_slt || take !== e_take) begin
      errors++;
      $display("FAIL %s_result: got eql=%b slt=%b take=%b want %b %b %b",
               name, eql, slt, take, e_eql, e_slt, e_take);
    end
    release_result();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: got rdy=%b vld=%b want 1 0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_compare();
    test_vector("eq_equal",    32'd5,        32'd5,        1'b0, 3'b000, 4, 1'b1, 1'b0, 1'b1);
    test_vector("lt_signed",   32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b010, 1, 1'b0, 1'b1, 1'b1);
    test_vector("lt_unsigned", 32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b010, 1, 1'b0, 1'b0, 1'b0);
    test_vector("ge_chunk1",   32'h12345600, 32'h12345700, 1'b0, 3'b011, 3, 1'b0, 1'b1, 1'b0);
    test_vector("gt_unsigned", 32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b101, 1, 1'b0, 1'b0, 1'b1);
    test_vector("gt_signed",   32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b101, 1, 1'b0, 1'b1, 1'b0);
    test_vector("reserved",    32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b110, 1, 1'b0, 1'b1, 1'b0);
    test_vector("le_chunk0",   32'h00000010, 32'h00000020, 1'b1, 3'b100, 4, 1'b0, 1'b1, 1'b1);
    test_vector("ne_equal",    32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 3'b001, 4, 1'b1, 1'b0, 1'b0);
    test_vector("gt_lowdiff",  32'h12345681, 32'h12345680, 1'b0, 3'b101, 4, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int lat;
    start_cmp(32'h12345600, 32'h12345700, 1'b0, 3'b100);
    wait_done(lat);
    checks++;
    if (lat != exp_lat(3)) begin
      errors++;
      $display("FAIL bp_latency: got %0d want %0d", lat, exp_lat(3));
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        @(negedge clk);
        a = 32'd9;
        b = 32'd9;
        cond = 3'b000;
        in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || eql !== 1'b0 || slt !== 1'b1 || take !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: got vld=%b rdy=%b eql=%b slt=%b take=%b want 1 0 0 1 1",
                 c, out_valid, in_ready, eql, slt, take);
      end
    end
    release_result();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || eql !== 1'b0 || slt !== 1'b1 || take !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b vld=%b eql=%b slt=%b take=%b want 1 0 0 1 1",
               in_ready, out_valid, eql, slt, take);
    end
    // The ignored pulse must not have started a second compare.
    repeat (NCHUNK + 1) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_ghost: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_scan();
    start_cmp(32'h00C0FFEE, 32'h00C0FFEE, 1'b0, 3'b000);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || eql !== 1'b0 || slt !== 1'b0 || take !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got vld=%b rdy=%b eql=%b slt=%b take=%b want 0 1 0 0 0",
               out_valid, in_ready, eql, slt, take);
    end
    repeat (NCHUNK) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: out_valid=%b want 0", out_valid);
    end
    test_vector("after_reset", 32'd7, 32'd7, 1'b0, 3'b001, 4, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    signed_cmp = 1'b0;
    cond = 3'b000;
    test_reset();
    test_compare();
    test_backpressure();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
